// File: rtl/disc_reader_pkg.sv
// Shared constants and types for the flux-timing reader.
package disc_reader_pkg;

   typedef logic [6:0] count_t;

   localparam count_t     CNT_MAX      = 7'd127;
   localparam logic [7:0] CARRY_BYTE   = 8'h7F;
   localparam int         IDX_FLAG_BIT = 7;

endpackage

// File: rtl/disc_edge_detect.sv
// Sample + delay flop pair on a raw drive input; rise is high for one cycle per rising edge.
module disc_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   logic s;
   logic p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= 1'b0;
         p <= 1'b0;
      end else begin
         s <= raw;
         p <= s;
      end
   end

   assign rise = s & ~p;

endmodule

// File: rtl/disc_reader.sv
// Turns floppy read-data / index edges into store and carry bytes of clock-enable counts.
// Optional index path is built only when DISC_READER_INDEX_EN is defined.
module disc_reader
   import disc_reader_pkg::*;
#(
   parameter int COUNT_W = 7
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             CLKEN,
   input  logic             RUN,
   input  logic             FD_RDDATA_IN,
   input  logic             FD_INDEX_IN,
   output logic [COUNT_W:0] DATA,
   output logic             WRITE
);

   count_t     cnt;
   logic       rd_rise;
   logic       pend_data;
   logic       data_evt;
   logic       idx_evt;
   logic       any_evt;
   logic       active;
   logic       at_max;
   logic [7:0] out_byte;

   assign active = RUN & CLKEN;
   assign at_max = (cnt == CNT_MAX);

   disc_edge_detect u_rd_edge (
      .clk  (CLOCK),
      .rst  (RESET),
      .raw  (FD_RDDATA_IN),
      .rise (rd_rise)
   );

   // An edge seen while CLKEN is low waits here until the next active cycle.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pend_data <= 1'b0;
      end else if (!RUN || CLKEN) begin
         pend_data <= 1'b0;
      end else if (rd_rise) begin
         pend_data <= 1'b1;
      end
   end

   assign data_evt = rd_rise | pend_data;

`ifdef DISC_READER_INDEX_EN
   logic idx_rise;
   logic pend_idx;

   disc_edge_detect u_idx_edge (
      .clk  (CLOCK),
      .rst  (RESET),
      .raw  (FD_INDEX_IN),
      .rise (idx_rise)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pend_idx <= 1'b0;
      end else if (!RUN || CLKEN) begin
         pend_idx <= 1'b0;
      end else if (idx_rise) begin
         pend_idx <= 1'b1;
      end
   end

   assign idx_evt = idx_rise | pend_idx;
`else
   logic unused_index;
   assign unused_index = FD_INDEX_IN;
   assign idx_evt      = 1'b0;
`endif

   assign any_evt = data_evt | idx_evt;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (!RUN) begin
         cnt <= '0;
      end else if (CLKEN) begin
         if (any_evt || at_max) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 7'd1;
         end
      end
   end

   // A real event wins over saturation, so an edge on cnt==127 is a store, not a carry.
   always_comb begin
      out_byte = {1'b0, cnt};
      if (any_evt) begin
         out_byte[IDX_FLAG_BIT] = idx_evt;
      end else if (at_max) begin
         out_byte = CARRY_BYTE;
      end
   end

   assign DATA  = out_byte;
   assign WRITE = active & (any_evt | at_max);

endmodule

// File: tb/tb_disc_reader.sv
// Directed self-checking bench for disc_reader; index expectations follow DISC_READER_INDEX_EN.
module tb_disc_reader;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       CLKEN = 1'b0;
   logic       RUN   = 1'b0;
   logic       rd    = 1'b0;
   logic       idx   = 1'b0;
   logic [7:0] DATA;
   logic       WRITE;

   int total = 0;
   int bad   = 0;

   logic [7:0] got_q[$];

   disc_reader dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .CLKEN        (CLKEN),
      .RUN          (RUN),
      .FD_RDDATA_IN (rd),
      .FD_INDEX_IN  (idx),
      .DATA         (DATA),
      .WRITE        (WRITE)
   );

   always #5 CLOCK = ~CLOCK;

   // Collect every written byte, sampled mid-cycle.
   always @(negedge CLOCK) begin
      if (WRITE === 1'b1) got_q.push_back(DATA);
   end

   // Advance n cycles; inputs are then driven 1ns after the rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      CLKEN = 1'b1;
      RUN   = 1'b0;
      rd    = 1'b0;
      idx   = 1'b0;
      cyc(10);
      @(negedge CLOCK);
      total++;
      if (WRITE !== 1'b0) begin
         bad++;
         $display("FAIL reset_write: got %b want 0", WRITE);
      end
      total++;
      if (DATA !== 8'h00) begin
         bad++;
         $display("FAIL reset_data: got %h want 00", DATA);
      end
      cyc(1);
      RESET = 1'b0;
   endtask

   task automatic test_first_byte;
      got_q.delete();
      RUN = 1'b1;
      rd  = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(5);
      total++;
      if (got_q.size() !== 1) begin
         bad++;
         $display("FAIL first_count: got %0d want 1", got_q.size());
      end else begin
         total++;
         if (got_q[0] !== 8'd1) begin
            bad++;
            $display("FAIL first_value: got %0d want 1", got_q[0]);
         end
      end
   endtask

   task automatic test_intervals;
      int lens[14] = '{1, 2, 5, 126, 127, 128, 129, 254, 255, 256, 300, 383, 384, 511};
      for (int t = 0; t < 14; t++) begin
         int i;
         int k;
         int rem;
         i   = lens[t];
         k   = i / 128;
         rem = i % 128;
         got_q.delete();
         rd = 1'b1;
         cyc(1);
         rd = 1'b0;
         cyc(i);
         rd = 1'b1;
         cyc(1);
         rd = 1'b0;
         cyc(5 + i / 127);
         total++;
         if (got_q.size() !== 2 + k) begin
            bad++;
            $display("FAIL interval_%0d_count: got %0d want %0d", i, got_q.size(), 2 + k);
         end else begin
            for (int c = 1; c <= k; c++) begin
               total++;
               if (got_q[c] !== 8'h7F) begin
                  bad++;
                  $display("FAIL interval_%0d_carry%0d: got %h want 7f", i, c, got_q[c]);
               end
            end
            total++;
            if (got_q[k + 1] !== rem[7:0]) begin
               bad++;
               $display("FAIL interval_%0d_store: got %0d want %0d", i, got_q[k + 1], rem);
            end
         end
      end
   endtask

   task automatic test_long_pulse;
      got_q.delete();
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(5);
      rd = 1'b1;
      cyc(50);
      rd = 1'b0;
      cyc(5);
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(5);
      total++;
      if (got_q.size() !== 3) begin
         bad++;
         $display("FAIL long_count: got %0d want 3", got_q.size());
      end else begin
         total++;
         if (got_q[1] !== 8'd5) begin
            bad++;
            $display("FAIL long_first: got %0d want 5", got_q[1]);
         end
         total++;
         if (got_q[2] !== 8'd54) begin
            bad++;
            $display("FAIL long_second: got %0d want 54", got_q[2]);
         end
      end
   endtask

   task automatic test_index;
      logic [7:0] b;
      got_q.delete();
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(20);
      idx = 1'b1;
      cyc(1);
      idx = 1'b0;
      cyc(5);
`ifdef DISC_READER_INDEX_EN
      total++;
      if (got_q.size() !== 2) begin
         bad++;
         $display("FAIL index_count: got %0d want 2", got_q.size());
      end else begin
         total++;
         if (got_q[1] !== 8'h94) begin
            bad++;
            $display("FAIL index_value: got %h want 94", got_q[1]);
         end
      end
`else
      total++;
      if (got_q.size() !== 1) begin
         bad++;
         $display("FAIL index_ignored_count: got %0d want 1", got_q.size());
      end
`endif
      got_q.delete();
      rd  = 1'b1;
      idx = 1'b1;
      cyc(1);
      rd  = 1'b0;
      idx = 1'b0;
      cyc(5);
      total++;
      if (got_q.size() !== 1) begin
         bad++;
         $display("FAIL both_count: got %0d want 1", got_q.size());
      end else begin
         b = got_q[0];
         total++;
`ifdef DISC_READER_INDEX_EN
         if (b[7] !== 1'b1) begin
            bad++;
            $display("FAIL both_flag: got %b want 1", b[7]);
         end
`else
         if (b[7] !== 1'b0) begin
            bad++;
            $display("FAIL both_flag: got %b want 0", b[7]);
         end
`endif
      end
   endtask

   task automatic test_clken;
      got_q.delete();
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(9);
      CLKEN = 1'b0;
      cyc(30);
      CLKEN = 1'b1;
      cyc(10);
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(5);
      total++;
      if (got_q.size() !== 2) begin
         bad++;
         $display("FAIL clken_count: got %0d want 2", got_q.size());
      end else begin
         total++;
         if (got_q[1] !== 8'd19) begin
            bad++;
            $display("FAIL clken_value: got %0d want 19", got_q[1]);
         end
      end

      got_q.delete();
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(4);
      CLKEN = 1'b0;
      cyc(3);
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(10);
      total++;
      if (got_q.size() !== 1) begin
         bad++;
         $display("FAIL pend_early: got %0d want 1", got_q.size());
      end
      CLKEN = 1'b1;
      cyc(3);
      total++;
      if (got_q.size() !== 2) begin
         bad++;
         $display("FAIL pend_count: got %0d want 2", got_q.size());
      end else begin
         total++;
         if (got_q[1] !== 8'd3) begin
            bad++;
            $display("FAIL pend_value: got %0d want 3", got_q[1]);
         end
      end
   endtask

   task automatic test_run_off;
      RUN = 1'b0;
      got_q.delete();
      cyc(2);
      for (int n = 0; n < 3; n++) begin
         rd = 1'b1;
         cyc(1);
         rd = 1'b0;
         cyc(4);
      end
      cyc(5);
      total++;
      if (got_q.size() !== 0) begin
         bad++;
         $display("FAIL run_off_writes: got %0d want 0", got_q.size());
      end
      rd = 1'b1;
      cyc(3);
      RUN = 1'b1;
      cyc(10);
      total++;
      if (got_q.size() !== 0) begin
         bad++;
         $display("FAIL run_level_high: got %0d want 0", got_q.size());
      end
      rd = 1'b0;
      cyc(1);
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(5);
      total++;
      if (got_q.size() !== 1) begin
         bad++;
         $display("FAIL run_resume_count: got %0d want 1", got_q.size());
      end else begin
         total++;
         if (got_q[0] !== 8'd12) begin
            bad++;
            $display("FAIL run_resume_value: got %0d want 12", got_q[0]);
         end
      end
   endtask

   task automatic test_reset_mid;
      RUN   = 1'b1;
      CLKEN = 1'b1;
      rd    = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(20);
      #2;
      RESET = 1'b1;
      #1;
      total++;
      if (WRITE !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_write: got %b want 0", WRITE);
      end
      total++;
      if (DATA !== 8'h00) begin
         bad++;
         $display("FAIL reset_mid_data: got %h want 00", DATA);
      end
      cyc(2);
      RESET = 1'b0;
      RUN   = 1'b0;
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_first_byte();
      test_intervals();
      test_long_pulse();
      test_index();
      test_clken();
      test_run_off();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
